// File: rtl/fifo_drain_reader.sv
// Burst-oriented consumer for the 8-bit FIFO: strobes reads, absorbs the 1-cycle read
// latency into a 2-entry skid buffer, and streams bytes out on valid/ready.
// Optional parity output enabled by defining FIFO_DRAIN_PARITY_EN.
module fifo_drain_reader #(
  parameter int BURST_W   = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic [BURST_W-1:0] in_burst_len,
  input  logic               in_abort,
  input  logic               fifo_is_empty,
  input  logic [7:0]         fifo_read_data,
  output logic               fifo_read_ctrl,
  output logic               out_valid,
  output logic [7:0]         out_data,
  input  logic               in_ready,
  output logic               out_busy,
  output logic               out_done,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic               out_parity,
`endif
  output logic [BURST_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

  state_t             state_r, state_s;
  logic [7:0]         buf_r [0:1];
  logic               rd_ptr_r, wr_ptr_r;
  logic [1:0]         occ_r;
  logic               inflight_r;
  logic [BURST_W-1:0] burst_len_r, reads_issued_r, count_r;
  logic               rd_s, push_s, pop_s;

  function automatic logic byte_parity(input logic [7:0] d);
    return ^d;
  endfunction

  assign push_s = inflight_r;
  assign pop_s  = (occ_r != 2'd0) && in_ready;

  // Next-state and read-strobe decision; abort wins over issuing a read.
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_start) begin
          if (in_burst_len == '0) state_s = S_DONE;
          else                    state_s = S_DRAIN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (in_abort || (reads_issued_r == burst_len_r)) begin
          state_s = S_FLUSH;
        end else if (!fifo_is_empty && !inflight_r &&
                     ((occ_r + {1'b0, inflight_r}) < DEPTH_C) &&
                     (reads_issued_r < burst_len_r)) begin
          rd_s = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
      end
      S_FLUSH: begin
        if (!inflight_r && (occ_r == 2'd0)) state_s = S_DONE;
        else                                state_s = S_FLUSH;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, skid buffer and burst counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      buf_r[0]       <= 8'd0;
      buf_r[1]       <= 8'd0;
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      occ_r          <= 2'd0;
      inflight_r     <= 1'b0;
      burst_len_r    <= '0;
      reads_issued_r <= '0;
      count_r        <= '0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_s;
      if (push_s) begin
        buf_r[wr_ptr_r] <= fifo_read_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
      if ((state_r == S_IDLE) && in_start) begin
        burst_len_r    <= in_burst_len;
        reads_issued_r <= '0;
        count_r        <= '0;
      end else begin
        if (rd_s)  reads_issued_r <= reads_issued_r + BURST_W'(1);
        if (pop_s) count_r        <= count_r + BURST_W'(1);
      end
    end
  end

  assign fifo_read_ctrl = rd_s;
  assign out_valid      = (occ_r != 2'd0);
  assign out_data       = buf_r[rd_ptr_r];
  assign out_busy       = (state_r == S_DRAIN) || (state_r == S_FLUSH);
  assign out_done       = (state_r == S_DONE);
  assign out_count      = count_r;
`ifdef FIFO_DRAIN_PARITY_EN
  assign out_parity     = byte_parity(out_data);
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Scoreboard bench for fifo_drain_reader: a FIFO model feeds bytes, tests push expected
// bytes into a queue, and a monitor pops and compares every accepted output byte.
module tb_fifo_drain_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_start = 1'b0;
  logic [7:0] in_burst_len = 8'd0;
  logic       in_abort = 1'b0;
  logic       fifo_is_empty = 1'b1;
  logic [7:0] fifo_read_data = 8'd0;
  logic       fifo_read_ctrl;
  logic       out_valid;
  logic [7:0] out_data;
  logic       in_ready = 1'b0;
  logic       out_busy;
  logic       out_done;
  logic [7:0] out_count;
`ifdef FIFO_DRAIN_PARITY_EN
  logic       out_parity;
`endif

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic rd_req = 1'b0;
  logic prev_rd = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] wr_mem [0:63];
  int wr_idx = 0;
  int model_idx = 0;

  fifo_drain_reader #(.BURST_W(8), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_burst_len(in_burst_len),
    .in_abort(in_abort), .fifo_is_empty(fifo_is_empty), .fifo_read_data(fifo_read_data),
    .fifo_read_ctrl(fifo_read_ctrl), .out_valid(out_valid), .out_data(out_data),
    .in_ready(in_ready), .out_busy(out_busy), .out_done(out_done),
`ifdef FIFO_DRAIN_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Sample the read strobe mid-cycle and police the issue rules.
  always @(negedge clk) begin
    rd_req = fifo_read_ctrl;
    if (fifo_read_ctrl === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (fq.size() == 0 || prev_rd) begin
        errors++;
        $display("FAIL strobe_rule empty=%0d prev_strobe=%0d required no strobe", fq.size() == 0, prev_rd);
      end
    end
    prev_rd = (fifo_read_ctrl === 1'b1);
  end

  // FIFO model: registered read data, writes become visible one edge after being queued.
  always @(posedge clk) begin
    logic [7:0] b;
    if (rd_req && fq.size() > 0) begin
      b = fq.pop_front();
      fifo_read_data <= b;
    end
    while (model_idx != wr_idx) begin
      fq.push_back(wr_mem[model_idx]);
      model_idx++;
    end
    fifo_is_empty <= (fq.size() == 0);
  end

  // Scoreboard monitor: each handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && out_valid === 1'b1 && in_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard unexpected byte got %h required none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL scoreboard data got %h required %h", out_data, e);
        end
`ifdef FIFO_DRAIN_PARITY_EN
        if (out_parity !== ^e) begin
          errors++;
          $display("FAIL parity got %b required %b", out_parity, ^e);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_out);
    wr_mem[wr_idx] = b;
    wr_idx++;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic start(input logic [7:0] len);
    tick();
    in_start = 1'b1;
    in_burst_len = len;
    tick();
    in_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [7:0] want_count);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_done === 1'b1) seen = 1;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_count"}, {24'd0, out_count}, {24'd0, want_count});
    @(negedge clk);
    chk({name, "_done_single"}, {31'd0, out_done}, 32'd0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_rd"},    {31'd0, fifo_read_ctrl}, 32'd0);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_data"},  {24'd0, out_data}, 32'd0);
    chk({name, "_busy"},  {31'd0, out_busy}, 32'd0);
    chk({name, "_done"},  {31'd0, out_done}, 32'd0);
    chk({name, "_count"}, {24'd0, out_count}, 32'd0);
  endtask

  initial begin
    int base;
    int n;
    // Asynchronous reset asserted between edges.
    #3 rst = 1'b1;
    #1 chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Basic burst.
    in_ready = 1'b1;
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    start(8'd3);
    wait_done("basic", 8'd3);

    // Backpressure: only two reads before the buffer stalls, head byte held.
    in_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1);
    base = strobe_cnt;
    start(8'd4);
    repeat (10) tick();
    chk("bp_strobes", strobe_cnt - base, 32'd2);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {24'd0, out_data}, 32'hA0);
    tick();
    chk("bp_data_stable", {24'd0, out_data}, 32'hA0);
    in_ready = 1'b1;
    wait_done("bp", 8'd4);

    // Starved FIFO.
    base = strobe_cnt;
    start(8'd2);
    repeat (6) tick();
    chk("starve_strobes", strobe_cnt - base, 32'd0);
    chk("starve_busy", {31'd0, out_busy}, 32'd1);
    push(8'h5A, 1); push(8'h5B, 1);
    wait_done("starve", 8'd2);

    // Zero-length burst.
    base = strobe_cnt;
    start(8'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, out_done}, 32'd1);
    chk("zero_busy", {31'd0, out_busy}, 32'd0);
    @(negedge clk);
    chk("zero_done_single", {31'd0, out_done}, 32'd0);
    chk("zero_strobes", strobe_cnt - base, 32'd0);
    chk("zero_count", {24'd0, out_count}, 32'd0);

    // Start during DRAIN is ignored.
    push(8'hC1, 1); push(8'hC2, 1);
    base = strobe_cnt;
    start(8'd2);
    in_start = 1'b1;
    in_burst_len = 8'd5;
    tick();
    in_start = 1'b0;
    wait_done("ign", 8'd2);
    chk("ign_strobes", strobe_cnt - base, 32'd2);

    // Abort after the third strobe.
    for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i), i < 3);
    base = strobe_cnt;
    start(8'd10);
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (fifo_read_ctrl === 1'b1) n++;
    end
    chk("abort_reach3", n, 32'd3);
    tick();
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    wait_done("abort", 8'd3);
    repeat (3) tick();
    chk("abort_strobes", strobe_cnt - base, 32'd3);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Reset mid-burst: everything cleared at once, no done pulse afterwards.
    in_ready = 1'b0;
    start(8'd4);
    repeat (4) tick();
    chk("mid_busy", {31'd0, out_busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_done === 1'b1 || out_busy === 1'b1) n++;
    end
    chk("midrst_quiet", n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
